// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file UART dumper.
// Build with REGDUMP_ASCII_EN to send hex text instead of raw bytes.
package regdump_pkg;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE    = 2'd0;
  localparam state_t S_ADDR    = 2'd1;
  localparam state_t S_CAPTURE = 2'd2;
  localparam state_t S_SEND    = 2'd3;

  typedef logic [1:0] ustate_t;
  localparam ustate_t U_IDLE  = 2'd0;
  localparam ustate_t U_START = 2'd1;
  localparam ustate_t U_DATA  = 2'd2;
  localparam ustate_t U_STOP  = 2'd3;

  localparam logic UART_START = 1'b0;
  localparam logic UART_STOP  = 1'b1;

  localparam int RAW_BYTES   = 4;
  localparam int ASCII_BYTES = 10;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

`ifdef REGDUMP_ASCII_EN
  localparam int DUMP_BYTES = ASCII_BYTES;

  function automatic logic [7:0] hex_char(
    input logic [3:0] n
  );
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else return 8'h37 + {4'h0, n};
  endfunction

  // Byte idx of one register: 8 hex chars MSB first, then CR LF.
  function automatic logic [7:0] dump_byte(
    input logic [31:0] w,
    input logic [3:0]  idx
  );
    logic [4:0] sh;
    sh = {3'd7 - idx[2:0], 2'b00};
    if (idx == 4'd8) return ASCII_CR;
    else if (idx == 4'd9) return ASCII_LF;
    else return hex_char(4'(w >> sh));
  endfunction
`else
  localparam int DUMP_BYTES = RAW_BYTES;

  function automatic logic [7:0] dump_byte(
    input logic [31:0] w,
    input logic [3:0]  idx
  );
    logic [6:0] sh;
    sh = {idx, 3'b000};
    return 8'(w >> sh);
  endfunction
`endif

endpackage

// File: rtl/regfile_dump_uart_tx.sv
// 8N1 byte serialiser; a load during the final stop cycle
// chains the next frame with no idle gap.
module uart_tx_byte
  import regdump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       load,
  output logic       tx,
  output logic       byte_done
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  ustate_t       st;
  logic [BW-1:0] baud;
  logic [2:0]    bitc;
  logic [7:0]    shreg;
  logic          baud_end;

  assign baud_end  = (baud == BAUD_MAX);
  assign byte_done = (st == U_STOP) && baud_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= U_IDLE;
      tx    <= UART_STOP;
      baud  <= '0;
      bitc  <= '0;
      shreg <= '0;
    end else begin
      unique case (st)
        U_IDLE: begin
          baud <= '0;
          bitc <= '0;
          if (load) begin
            st    <= U_START;
            tx    <= UART_START;
            shreg <= byte_in;
          end
        end
        U_START: begin
          if (baud_end) begin
            baud <= '0;
            st   <= U_DATA;
            tx   <= shreg[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        U_DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bitc == 3'd7) begin
              bitc <= '0;
              st   <= U_STOP;
              tx   <= UART_STOP;
            end else begin
              bitc  <= bitc + 3'd1;
              tx    <= shreg[1];
              shreg <= shreg >> 1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        U_STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (load) begin
              st    <= U_START;
              tx    <= UART_START;
              shreg <= byte_in;
            end else begin
              st <= U_IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: st <= U_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/regfile_dump_uart.sv
// Walks FIRST_REG..LAST_REG over a spare read port and streams each
// value out the UART (raw LSB-first, or hex text with REGDUMP_ASCII_EN).
module regfile_dump_uart
  import regdump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIRST_REG    = 0,
  parameter int LAST_REG     = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST_A   = 5'(FIRST_REG);
  localparam logic [4:0] LAST_A    = 5'(LAST_REG);
  localparam logic [3:0] LAST_BYTE = 4'(DUMP_BYTES - 1);

  state_t      state;
  logic [31:0] word;
  logic [3:0]  byte_cnt;
  logic        load;
  logic        byte_done;
  logic [7:0]  byte_in;
  logic        last_byte;

  assign busy      = (state != S_IDLE);
  assign last_byte = (byte_cnt == LAST_BYTE);

  // First byte comes straight off the read port so framing starts
  // on the capture edge; later bytes come from the latched word.
  always_comb begin
    load    = 1'b0;
    byte_in = dump_byte(word, byte_cnt + 4'd1);
    if (state == S_CAPTURE) begin
      load    = 1'b1;
      byte_in = dump_byte(rd_data, 4'd0);
    end else if (state == S_SEND) begin
      load = byte_done && !last_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rd_addr  <= FIRST_A;
      word     <= '0;
      byte_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_ADDR;
            rd_addr  <= FIRST_A;
            byte_cnt <= '0;
          end
        end
        S_ADDR: state <= S_CAPTURE;
        S_CAPTURE: begin
          word     <= rd_data;
          byte_cnt <= '0;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (byte_done) begin
            if (!last_byte) begin
              byte_cnt <= byte_cnt + 4'd1;
            end else if (rd_addr == LAST_A) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end else begin
              rd_addr  <= rd_addr + 5'd1;
              byte_cnt <= '0;
              state    <= S_ADDR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .byte_in  (byte_in),
    .load     (load),
    .tx       (tx),
    .byte_done(byte_done)
  );

endmodule
